// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared constants, state type and map-size helper for the LSTM weight loader
//
// Contents:
//   WEIGHTS            gate weight sets per LSTM layer
//   LSTM_CTRL_RUN      value written to the control register to start the LSTM
//   loader_state_t     loader FSM states
//   lstm_num_addresses number of register map entries for a given layer count
package lstm_pkg;

    localparam int WEIGHTS = 4;

    localparam logic [31:0] LSTM_CTRL_RUN = 32'h1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_RUN   = 2'd3
    } loader_state_t;

    // Four words per gate weight set, two bias-style words per layer, plus
    // the control register at the top of the map.
    function automatic int lstm_num_addresses(input int layers);
        return 4 * (layers * WEIGHTS) + 2 * layers + 1;
    endfunction

endpackage

// File: rtl/lstm_write_addr_gen.sv
// rtl/lstm_write_addr_gen.sv - data word counter with matching OFFSET+4*cnt byte address register
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   i_clear      restart at word 0 / address OFFSET (has priority over i_inc)
//   i_inc        advance to the next word
//   o_addr       byte address of the current word (OFFSET + 4*cnt)
//   o_last       current word is the final data word (cnt == NUM_DATA-1)
module lstm_write_addr_gen
    import lstm_pkg::*;
#(
    parameter logic [31:0] OFFSET   = 32'h0,
    parameter int          NUM_DATA = 54
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_inc,
    output logic [31:0] o_addr,
    output logic        o_last
);

    localparam int            CW       = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_DATA - 1);

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;

    // The address is kept as its own register stepping by 4 so no multiply
    // or add of OFFSET sits on the path from the counter to the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_addr <= OFFSET;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_addr <= OFFSET;
        end else if (i_inc) begin
            r_cnt  <= r_cnt + CW'(1);
            r_addr <= r_addr + 32'd4;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/lstm_weight_loader.sv
// rtl/lstm_weight_loader.sv - streams LSTM weight/bias words onto the register bus, then writes the run control
//
// Optional feature macro: LSTM_LOADER_CHECKSUM_EN (trailing checksum word, error flag)
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, abort      begin a load (only from idle) / cancel the load in progress
//   s_data, s_valid   stream word and its valid
//   s_ready           stream accept (combinational)
//   address           bus byte address (registered)
//   write_data        bus write data (registered)
//   write_en          one-cycle write strobe (registered)
//   busy              loader not idle
//   done              one-cycle completion pulse (registered)
//   error             checksum mismatch, sticky until next start (0 without the feature)
module lstm_weight_loader
    import lstm_pkg::*;
#(
    parameter logic [31:0] OFFSET = 32'h0,
    parameter int          LAYERS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic        write_en,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int          NUM_ADDRESSES = lstm_num_addresses(LAYERS);
    localparam int          NUM_DATA      = NUM_ADDRESSES - 1;
    localparam logic [31:0] CTRL_ADDR     = OFFSET + 32'(4 * NUM_DATA);

    loader_state_t r_state;

    logic        w_accept;
    logic        w_start_load;
    logic        w_gen_inc;
    logic        w_gen_last;
    logic [31:0] w_gen_addr;

`ifdef LSTM_LOADER_CHECKSUM_EN
    logic [31:0] r_sum;
`else
    assign error = 1'b0;
`endif

    // abort gates s_ready so an aborting cycle never consumes a word.
    assign s_ready      = ((r_state == ST_LOAD) || (r_state == ST_CHECK)) && !abort;
    assign busy         = (r_state != ST_IDLE);
    assign w_accept     = s_valid && s_ready;
    assign w_start_load = (r_state == ST_IDLE) && start && !abort;
    assign w_gen_inc    = w_accept && (r_state == ST_LOAD);

    lstm_write_addr_gen #(
        .OFFSET   (OFFSET),
        .NUM_DATA (NUM_DATA)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_start_load),
        .i_inc   (w_gen_inc),
        .o_addr  (w_gen_addr),
        .o_last  (w_gen_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            address    <= '0;
            write_data <= '0;
            write_en   <= 1'b0;
            done       <= 1'b0;
`ifdef LSTM_LOADER_CHECKSUM_EN
            error      <= 1'b0;
            r_sum      <= '0;
`endif
        end else begin
            write_en <= 1'b0;
            done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_load) begin
                        r_state <= ST_LOAD;
`ifdef LSTM_LOADER_CHECKSUM_EN
                        error   <= 1'b0;
                        r_sum   <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_accept) begin
                        write_en   <= 1'b1;
                        address    <= w_gen_addr;
                        write_data <= s_data;
`ifdef LSTM_LOADER_CHECKSUM_EN
                        r_sum      <= r_sum + s_data;
                        if (w_gen_last) r_state <= ST_CHECK;
`else
                        if (w_gen_last) r_state <= ST_RUN;
`endif
                    end
                end
`ifdef LSTM_LOADER_CHECKSUM_EN
                // The trailer word is consumed but never written to the bus.
                ST_CHECK: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_accept) begin
                        if (s_data == r_sum) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= ST_IDLE;
                            error   <= 1'b1;
                            done    <= 1'b1;
                        end
                    end
                end
`endif
                ST_RUN: begin
                    write_en   <= 1'b1;
                    address    <= CTRL_ADDR;
                    write_data <= LSTM_CTRL_RUN;
                    done       <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_weight_loader.sv
// tb/tb_lstm_weight_loader.sv - randomized self-checking bench for lstm_weight_loader
`timescale 1ns/1ps
module tb_lstm_weight_loader;

    localparam logic [31:0] OFFSET    = 32'h0;
    localparam int          LAYERS    = 3;
    localparam int          NUM_DATA  = (16 * LAYERS + 2 * LAYERS + 1) - 1;
    localparam logic [31:0] CTRL_ADDR = OFFSET + 32'(4 * NUM_DATA);

    logic        clk = 1'b0;
    logic        reset, start, abort, s_valid;
    logic [31:0] s_data;
    logic        s_ready, write_en, busy, done, error;
    logic [31:0] address, write_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int idle_ready_viol = 0;

    logic [31:0] words[$];
    logic [31:0] exp_a[$], exp_d[$];
    logic [31:0] wa[$], wd[$];
    int          wc[$], acc_cyc[$], dc[$];
    logic        db[$], de[$];

    lstm_weight_loader #(.OFFSET(OFFSET), .LAYERS(LAYERS)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .address(address), .write_data(write_data), .write_en(write_en),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus / stream monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (s_valid && s_ready) acc_cyc.push_back(cyc);
            if (write_en) begin
                wa.push_back(address); wd.push_back(write_data); wc.push_back(cyc);
            end
            if (done) begin
                dc.push_back(cyc); db.push_back(busy); de.push_back(error);
            end
            if (s_ready && !busy) idle_ready_viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete(); acc_cyc.delete();
        dc.delete(); db.delete(); de.delete();
        idle_ready_viol = 0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Reference stream: data words, plus a wrapping-sum trailer when checksums are on.
    task automatic make_words(input bit rnd);
        words.delete();
        for (int i = 0; i < NUM_DATA; i++) words.push_back(rnd ? $urandom : 32'(i));
`ifdef LSTM_LOADER_CHECKSUM_EN
        begin
            logic [31:0] sum;
            sum = '0;
            foreach (words[i]) sum += words[i];
            words.push_back(sum);
        end
`endif
    endtask

    // Expected bus writes: word i at OFFSET+4i, optionally the run write.
    task automatic build_expect(input int n_data, input bit with_ctrl);
        exp_a.delete(); exp_d.delete();
        for (int i = 0; i < n_data; i++) begin
            exp_a.push_back(OFFSET + 32'(4 * i));
            exp_d.push_back(words[i]);
        end
        if (with_ctrl) begin
            exp_a.push_back(CTRL_ADDR);
            exp_d.push_back(32'h1);
        end
    endtask

    // Offers words[from..upto-1] with random valid gaps; idx is the next word index.
    task automatic feed(input int gap_pct, input int from, input int upto, output int idx);
        int budget;
        idx = from;
        budget = 0;
        while (idx < upto && budget < 5000) begin
            s_valid = ($urandom_range(0, 99) >= gap_pct);
            s_data  = words[idx];
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            @(posedge clk); #1;
            budget++;
        end
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic test_reset();
        checks++;
        if ({write_en, done, error, busy, s_ready, address, write_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b done=%b err=%b busy=%b rdy=%b addr=%h data=%h, expected all 0",
                     write_en, done, error, busy, s_ready, address, write_data);
        end
        reset = 1'b0;
        s_valid = 1'b1;
        settle(2);
        checks++;
        if (s_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_ready: got rdy=%b busy=%b, expected 0 0", s_ready, busy);
        end
        s_valid = 1'b0;
        settle(1);
    endtask

    task automatic test_full_load(input int gap_pct, input bit rnd, input int poke_at, input string tag);
        int idx, n;
        make_words(rnd);
        n = words.size();
        clear_log();
        pulse_start();
        if (poke_at >= 0) begin
            feed(gap_pct, 0, poke_at, idx);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_busy_after_start: got %b expected 1", tag, busy);
            end
            feed(gap_pct, idx, n, idx);
        end else begin
            feed(gap_pct, 0, n, idx);
        end
        settle(4);
        build_expect(NUM_DATA, 1'b1);
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL %s_accepts: got %0d expected %0d", tag, idx, n);
        end
        checks++;
        if (wa.size() != exp_a.size()) begin
            errors++;
            $display("FAIL %s_write_count: got %0d expected %0d", tag, wa.size(), exp_a.size());
        end else begin
            for (int i = 0; i < exp_a.size(); i++) begin
                checks++;
                if (wa[i] !== exp_a[i] || wd[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL %s_write[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                             tag, i, wa[i], wd[i], exp_a[i], exp_d[i]);
                end
            end
            for (int k = 0; k < NUM_DATA; k++) begin
                checks++;
                if (wc[k] != acc_cyc[k] + 1) begin
                    errors++;
                    $display("FAIL %s_write_timing[%0d]: got cycle %0d expected %0d", tag, k, wc[k], acc_cyc[k] + 1);
                end
            end
        end
        checks++;
        if (dc.size() != 1 || acc_cyc.size() == 0 || dc[0] != acc_cyc[acc_cyc.size()-1] + 2) begin
            errors++;
            $display("FAIL %s_done_timing: got %0d pulses first at %0d, expected 1 pulse at %0d", tag,
                     dc.size(), (dc.size() > 0) ? dc[0] : -1,
                     (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] + 2 : -1);
        end else begin
            checks++;
            if (db[0] !== 1'b0 || de[0] !== 1'b0) begin
                errors++;
                $display("FAIL %s_done_flags: got busy=%b error=%b expected 0 0", tag, db[0], de[0]);
            end
        end
        checks++;
        if (idle_ready_viol != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_state: got ready_in_idle=%0d busy=%b expected 0 0", tag, idle_ready_viol, busy);
        end
    endtask

    task automatic test_abort();
        int idx, ctrl_hits;
        make_words(1'b0);
        clear_log();
        pulse_start();
        feed(0, 0, 10, idx);
        abort = 1'b1;
        s_valid = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready: got %b expected 0", s_ready);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        s_valid = 1'b0;
        settle(3);
        build_expect(10, 1'b0);
        ctrl_hits = 0;
        foreach (wa[i]) if (wa[i] == CTRL_ADDR) ctrl_hits++;
        checks++;
        if (wa.size() != 10 || ctrl_hits != 0) begin
            errors++;
            $display("FAIL abort_write_count: got %0d writes %0d ctrl, expected 10 writes 0 ctrl", wa.size(), ctrl_hits);
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (wa[i] !== exp_a[i] || wd[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL abort_write[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                             i, wa[i], wd[i], exp_a[i], exp_d[i]);
                end
            end
        end
        checks++;
        if (dc.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses busy=%b expected 0 0", dc.size(), busy);
        end
        test_full_load(0, 1'b0, -1, "reload");
    endtask

    task automatic test_start_abort();
        clear_log();
        start = 1'b1;
        abort = 1'b1;
        s_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        settle(2);
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || wa.size() != 0) begin
            errors++;
            $display("FAIL start_abort: got busy=%b rdy=%b writes=%0d expected 0 0 0", busy, s_ready, wa.size());
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int idx;
        make_words(1'b0);
        clear_log();
        pulse_start();
        feed(0, 0, 20, idx);
        checks++;
        if (write_en !== 1'b1 || address !== OFFSET + 32'(4 * 19)) begin
            errors++;
            $display("FAIL pre_reset_write: got en=%b addr=%h expected 1 %h", write_en, address, OFFSET + 32'(4 * 19));
        end
        s_valid = 1'b1;
        s_data = words[20];
        reset = 1'b1;
        #1;
        checks++;
        if ({write_en, done, error, busy, s_ready, address, write_data} !== '0) begin
            errors++;
            $display("FAIL async_reset: got en=%b done=%b err=%b busy=%b rdy=%b addr=%h data=%h, expected all 0",
                     write_en, done, error, busy, s_ready, address, write_data);
        end
        settle(2);
        reset = 1'b0;
        clear_log();
        settle(4);
        s_valid = 1'b0;
        checks++;
        if (wa.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: got %0d writes busy=%b expected 0 0", wa.size(), busy);
        end
        test_full_load(0, 1'b0, -1, "post_reset");
    endtask

`ifdef LSTM_LOADER_CHECKSUM_EN
    task automatic test_checksum_bad();
        int idx, ctrl_hits;
        make_words(1'b0);
        words[words.size()-1] = 32'h0;
        clear_log();
        pulse_start();
        feed(0, 0, words.size(), idx);
        settle(4);
        ctrl_hits = 0;
        foreach (wa[i]) if (wa[i] == CTRL_ADDR) ctrl_hits++;
        checks++;
        if (idx != NUM_DATA + 1 || wa.size() != NUM_DATA || ctrl_hits != 0) begin
            errors++;
            $display("FAIL csum_bad_writes: got accepts=%0d writes=%0d ctrl=%0d expected %0d %0d 0",
                     idx, wa.size(), ctrl_hits, NUM_DATA + 1, NUM_DATA);
        end
        checks++;
        if (dc.size() != 1 || acc_cyc.size() == 0 || dc[0] != acc_cyc[acc_cyc.size()-1] + 1) begin
            errors++;
            $display("FAIL csum_bad_done: got %0d pulses, expected 1 pulse one cycle after trailer", dc.size());
        end else begin
            checks++;
            if (de[0] !== 1'b1 || db[0] !== 1'b0) begin
                errors++;
                $display("FAIL csum_bad_flags: got error=%b busy=%b expected 1 0", de[0], db[0]);
            end
        end
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL csum_error_sticky: got %b expected 1", error);
        end
        pulse_start();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL csum_error_clear: got error=%b busy=%b expected 0 1", error, busy);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        settle(1);
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        settle(3);
        test_reset();
        test_full_load(0, 1'b0, -1, "full");
        test_full_load(50, 1'b1, -1, "gaps");
        test_abort();
        test_start_abort();
        test_full_load(30, 1'b1, 7, "busy_start");
        test_reset_mid_load();
`ifdef LSTM_LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
